// File: rtl/uart_cmd_decoder_if.sv
// Bundle between the UART receiver and the command decoder / system core.
// master: RX byte source and strobe consumer; slave: the decoder.
interface uart_cmd_decoder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] RX_P_DATA;
  logic                  RX_D_VLD;
  logic                  RX_ERR;
  logic [ADDR_WIDTH-1:0] RF_ADDR;
  logic [DATA_WIDTH-1:0] RF_WR_DATA;
  logic                  RF_WR_EN;
  logic                  RF_RD_EN;
  logic [3:0]            ALU_FUN;
  logic                  ALU_EN;
  logic                  CMD_ERR;

  modport master (
    output RX_P_DATA, RX_D_VLD, RX_ERR,
    input  RF_ADDR, RF_WR_DATA, RF_WR_EN, RF_RD_EN, ALU_FUN, ALU_EN, CMD_ERR
  );

  modport slave (
    input  RX_P_DATA, RX_D_VLD, RX_ERR,
    output RF_ADDR, RF_WR_DATA, RF_WR_EN, RF_RD_EN, ALU_FUN, ALU_EN, CMD_ERR
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Parses UART command frames into 1-cycle RF write/read and ALU strobes; all outputs registered.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module uart_cmd_decoder #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                CLK,
  input logic                RST,
  uart_cmd_decoder_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, OP_FUN, NOP_FUN
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_hold, addr_hold_nxt;
  logic [ADDR_WIDTH-1:0] rf_addr, rf_addr_nxt;
  logic [DATA_WIDTH-1:0] rf_wr_data, rf_wr_data_nxt;
  logic [3:0]            alu_fun, alu_fun_nxt;
  logic                  rf_wr_en, rf_wr_en_nxt;
  logic                  rf_rd_en, rf_rd_en_nxt;
  logic                  alu_en, alu_en_nxt;
  logic                  cmd_err, cmd_err_nxt;
  logic                  timeout_hit;

  logic [ADDR_WIDTH-1:0] byte_addr;
  logic [3:0]            byte_fun;

  assign byte_addr = bus.RX_P_DATA[ADDR_WIDTH-1:0];
  assign byte_fun  = bus.RX_P_DATA[3:0];

`ifdef CMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] gap_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      gap_cnt <= '0;
    else if (bus.RX_D_VLD || state == IDLE)
      gap_cnt <= '0;
    else
      gap_cnt <= gap_cnt + CNT_W'(1);
  end

  // A byte on the terminal-count cycle takes priority over the timeout.
  assign timeout_hit = (state != IDLE) && !bus.RX_D_VLD &&
                       (gap_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    addr_hold_nxt  = addr_hold;
    rf_addr_nxt    = rf_addr;
    rf_wr_data_nxt = rf_wr_data;
    alu_fun_nxt    = alu_fun;
    rf_wr_en_nxt   = 1'b0;
    rf_rd_en_nxt   = 1'b0;
    alu_en_nxt     = 1'b0;
    cmd_err_nxt    = 1'b0;

    if (bus.RX_D_VLD) begin
      if (bus.RX_ERR) begin
        state_nxt   = IDLE;
        cmd_err_nxt = 1'b1;
      end else begin
        case (state)
          IDLE: begin
            case (bus.RX_P_DATA)
              DATA_WIDTH'(8'hAA): state_nxt = WR_ADDR;
              DATA_WIDTH'(8'hBB): state_nxt = RD_ADDR;
              DATA_WIDTH'(8'hCC): state_nxt = OP_A;
              DATA_WIDTH'(8'hDD): state_nxt = NOP_FUN;
              default:            cmd_err_nxt = 1'b1;
            endcase
          end
          WR_ADDR: begin
            addr_hold_nxt = byte_addr;
            state_nxt     = WR_DATA;
          end
          WR_DATA: begin
            rf_addr_nxt    = addr_hold;
            rf_wr_data_nxt = bus.RX_P_DATA;
            rf_wr_en_nxt   = 1'b1;
            state_nxt      = IDLE;
          end
          RD_ADDR: begin
            rf_addr_nxt  = byte_addr;
            rf_rd_en_nxt = 1'b1;
            state_nxt    = IDLE;
          end
          OP_A: begin
            rf_addr_nxt    = '0;
            rf_wr_data_nxt = bus.RX_P_DATA;
            rf_wr_en_nxt   = 1'b1;
            state_nxt      = OP_B;
          end
          OP_B: begin
            rf_addr_nxt    = ADDR_WIDTH'(1);
            rf_wr_data_nxt = bus.RX_P_DATA;
            rf_wr_en_nxt   = 1'b1;
            state_nxt      = OP_FUN;
          end
          OP_FUN, NOP_FUN: begin
            alu_fun_nxt = byte_fun;
            alu_en_nxt  = 1'b1;
            state_nxt   = IDLE;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end else if (timeout_hit) begin
      state_nxt   = IDLE;
      cmd_err_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      addr_hold  <= '0;
      rf_addr    <= '0;
      rf_wr_data <= '0;
      alu_fun    <= '0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      alu_en     <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr_hold  <= addr_hold_nxt;
      rf_addr    <= rf_addr_nxt;
      rf_wr_data <= rf_wr_data_nxt;
      alu_fun    <= alu_fun_nxt;
      rf_wr_en   <= rf_wr_en_nxt;
      rf_rd_en   <= rf_rd_en_nxt;
      alu_en     <= alu_en_nxt;
      cmd_err    <= cmd_err_nxt;
    end
  end

  assign bus.RF_ADDR    = rf_addr;
  assign bus.RF_WR_DATA = rf_wr_data;
  assign bus.RF_WR_EN   = rf_wr_en;
  assign bus.RF_RD_EN   = rf_rd_en;
  assign bus.ALU_FUN    = alu_fun;
  assign bus.ALU_EN     = alu_en;
  assign bus.CMD_ERR    = cmd_err;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder; output vector = {wr,rd,alu,err,addr[3:0],data[7:0],fun[3:0]}.
module tb_uart_cmd_decoder;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   total = 0;
  int   bad   = 0;

  uart_cmd_decoder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  uart_cmd_decoder #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [19:0] outs();
    return {bus.RF_WR_EN, bus.RF_RD_EN, bus.ALU_EN, bus.CMD_ERR,
            bus.RF_ADDR, bus.RF_WR_DATA, bus.ALU_FUN};
  endfunction

  function automatic logic [19:0] ev(logic wr, logic rd, logic alu, logic err,
                                     logic [3:0] a, logic [7:0] d, logic [3:0] f);
    return {wr, rd, alu, err, a, d, f};
  endfunction

  task automatic chk(input string tag, input logic [19:0] exp);
    logic [19:0] obs;
    obs = outs();
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  // Drives one valid byte; returns 1 time unit after the edge that captures it.
  task automatic send(input logic [7:0] b, input logic e);
    bus.RX_P_DATA = b;
    bus.RX_ERR    = e;
    bus.RX_D_VLD  = 1'b1;
    @(posedge CLK);
    #1;
    bus.RX_D_VLD  = 1'b0;
    bus.RX_ERR    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    bus.RX_P_DATA = '0;
    bus.RX_D_VLD  = 1'b0;
    bus.RX_ERR    = 1'b0;
    idle(2);
    chk("reset", ev(0,0,0,0, 4'h0, 8'h00, 4'h0));
    @(negedge CLK);
    RST = 1'b1;
    idle(1);

    // AA 05 3C
    send(8'hAA, 0); chk("wr_op",   ev(0,0,0,0, 4'h0, 8'h00, 4'h0));
    send(8'h05, 0); chk("wr_addr", ev(0,0,0,0, 4'h0, 8'h00, 4'h0));
    send(8'h3C, 0); chk("wr_strb", ev(1,0,0,0, 4'h5, 8'h3C, 4'h0));
    idle(1);        chk("wr_hold", ev(0,0,0,0, 4'h5, 8'h3C, 4'h0));

    // CC 12 34 03
    send(8'hCC, 0); chk("cc_op",   ev(0,0,0,0, 4'h5, 8'h3C, 4'h0));
    send(8'h12, 0); chk("cc_a",    ev(1,0,0,0, 4'h0, 8'h12, 4'h0));
    send(8'h34, 0); chk("cc_b",    ev(1,0,0,0, 4'h1, 8'h34, 4'h0));
    send(8'h03, 0); chk("cc_fun",  ev(0,0,1,0, 4'h1, 8'h34, 4'h3));

    // BB 0A DD 07 on consecutive cycles
    send(8'hBB, 0); chk("rd_op",   ev(0,0,0,0, 4'h1, 8'h34, 4'h3));
    send(8'h0A, 0); chk("rd_strb", ev(0,1,0,0, 4'hA, 8'h34, 4'h3));
    send(8'hDD, 0); chk("dd_op",   ev(0,0,0,0, 4'hA, 8'h34, 4'h3));
    send(8'h07, 0); chk("dd_fun",  ev(0,0,1,0, 4'hA, 8'h34, 4'h7));
    idle(1);        chk("dd_hold", ev(0,0,0,0, 4'hA, 8'h34, 4'h7));

    // Upper bits of addr and fun are ignored
    send(8'hAA, 0); send(8'hF9, 0);
    send(8'h5A, 0); chk("wr_hiaddr", ev(1,0,0,0, 4'h9, 8'h5A, 4'h7));
    send(8'hDD, 0);
    send(8'hA6, 0); chk("dd_hifun",  ev(0,0,1,0, 4'h9, 8'h5A, 4'h6));

    // Bad opcode, errored data byte, then recovery
    idle(2);
    send(8'h55, 0); chk("bad_op",   ev(0,0,0,1, 4'h9, 8'h5A, 4'h6));
    idle(1);        chk("err_1cyc", ev(0,0,0,0, 4'h9, 8'h5A, 4'h6));
    send(8'hAA, 0); send(8'h02, 0);
    send(8'h99, 1); chk("rx_err",   ev(0,0,0,1, 4'h9, 8'h5A, 4'h6));
    send(8'hAA, 0); chk("rec_op",   ev(0,0,0,0, 4'h9, 8'h5A, 4'h6));
    send(8'h02, 0);
    send(8'h11, 0); chk("rec_wr",   ev(1,0,0,0, 4'h2, 8'h11, 4'h6));

    // Errored opcode leaves the decoder in IDLE: next byte is an opcode
    send(8'hAA, 1); chk("op_err",   ev(0,0,0,1, 4'h2, 8'h11, 4'h6));
    send(8'h05, 0); chk("op_after", ev(0,0,0,1, 4'h2, 8'h11, 4'h6));

    // Async reset between opcode and address
    idle(1);
    send(8'hAA, 0);
    @(negedge CLK);
    RST = 1'b0;
    #1;             chk("arst",     ev(0,0,0,0, 4'h0, 8'h00, 4'h0));
    @(negedge CLK);
    RST = 1'b1;
    idle(1);
    send(8'hBB, 0); chk("post_op",  ev(0,0,0,0, 4'h0, 8'h00, 4'h0));
    send(8'h04, 0); chk("post_rd",  ev(0,1,0,0, 4'h4, 8'h00, 4'h0));

`ifdef CMD_TIMEOUT_EN
    // Stall after opcode: error 16 cycles after the opcode edge
    send(8'hAA, 0);
    idle(15);       chk("to_pre",   ev(0,0,0,0, 4'h4, 8'h00, 4'h0));
    idle(1);        chk("to_err",   ev(0,0,0,1, 4'h4, 8'h00, 4'h0));
    send(8'hBB, 0);
    send(8'h03, 0); chk("to_idle",  ev(0,1,0,0, 4'h3, 8'h00, 4'h0));
    // 15-cycle gap before the data byte still completes
    send(8'hAA, 0); send(8'h01, 0);
    idle(15);       chk("gap_quiet", ev(0,0,0,0, 4'h3, 8'h00, 4'h0));
    send(8'h77, 0); chk("gap_wr",   ev(1,0,0,0, 4'h1, 8'h77, 4'h0));
`else
    // Without the timeout a partial frame waits indefinitely
    send(8'hAA, 0); send(8'h01, 0);
    idle(40);       chk("wait_quiet", ev(0,0,0,0, 4'h4, 8'h00, 4'h0));
    send(8'h77, 0); chk("wait_wr",  ev(1,0,0,0, 4'h1, 8'h77, 4'h0));
`endif

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
